// File: rtl/reg_alu_core.sv
// reg_alu_core: register file with a multi-cycle ALU and a bit-serial shifter.
// Define REG_ALU_MULT_EN to add the shift-add multiplier on Op 0011.
module reg_alu_core #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [AW-1:0]    RS1,
  input  logic [AW-1:0]    RS2,
  input  logic [AW-1:0]    RD,
  input  logic [SW-1:0]    ShiftCount,
  input  logic             ExtWE,
  input  logic [AW-1:0]    ExtWR,
  input  logic [WIDTH-1:0] ExtWD,
  input  logic [AW-1:0]    DbgAddr,
  output logic [WIDTH-1:0] DbgData,
  output logic             Busy,
  output logic             Done,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] Result
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SGT = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_SRA = 4'b1111;
  localparam int         MSB    = WIDTH - 1;
  localparam logic [SW:0] CNT_ONE = (SW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SHIFT,
    S_WB
`ifdef REG_ALU_MULT_EN
    , S_MUL
`endif
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic [SW:0]      cnt;

  logic [WIDTH-1:0] sum, diff, alu_res, shift_nx;
  logic [WIDTH-1:0] wb_val;
  logic             alu_ov, wb_ov, wb_en, op_shift;

`ifdef REG_ALU_MULT_EN
  localparam logic [3:0]  OP_MUL  = 4'b0011;
  localparam logic [SW:0] CNT_MUL = (SW+1)'(WIDTH);
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH:0]   mul_sum;

  assign mul_sum = {1'b0, p_hi} + (b_q[0] ? {1'b0, a_q} : '0);
`endif

  assign DbgData  = regs[DbgAddr];
  assign op_shift = (Op == OP_SRL) || (Op == OP_SLL) || (Op == OP_SRA);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    Busy     = (state != S_IDLE);
    wb_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Start) begin
          if (op_shift && ShiftCount != '0) state_nx = S_SHIFT;
`ifdef REG_ALU_MULT_EN
          else if (Op == OP_MUL) state_nx = S_MUL;
`endif
          else state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        wb_en    = 1'b1;
        state_nx = S_IDLE;
      end
      S_SHIFT: if (cnt == CNT_ONE) state_nx = S_WB;
`ifdef REG_ALU_MULT_EN
      S_MUL: if (cnt == CNT_ONE) state_nx = S_WB;
`endif
      S_WB: begin
        wb_en    = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    sum     = a_q + b_q;
    diff    = a_q - b_q;
    alu_res = '0;
    alu_ov  = 1'b0;
    case (op_q)
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_ADD: begin
        alu_res = sum;
        alu_ov  = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ov  = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OP_SGT: alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) > $signed(b_q)};
      OP_NOR: alu_res = ~(a_q | b_q);
      // shifter leaves the finished value in a_q
      OP_SRL, OP_SLL, OP_SRA: alu_res = a_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    shift_nx = a_q;
    case (op_q)
      OP_SRL:  shift_nx = {1'b0, a_q[MSB:1]};
      OP_SRA:  shift_nx = {a_q[MSB], a_q[MSB:1]};
      OP_SLL:  shift_nx = {a_q[MSB-1:0], 1'b0};
      default: shift_nx = a_q;
    endcase
  end

  always_comb begin
    wb_val = alu_res;
    wb_ov  = alu_ov;
`ifdef REG_ALU_MULT_EN
    if (op_q == OP_MUL) begin
      wb_val = b_q;
      wb_ov  = |p_hi;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      cnt      <= '0;
      Done     <= 1'b0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      Result   <= '0;
`ifdef REG_ALU_MULT_EN
      p_hi     <= '0;
`endif
    end else begin
      Done <= wb_en;
      if (wb_en) begin
        Result   <= wb_val;
        Zero     <= (wb_val == '0);
        Overflow <= wb_ov;
      end
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            a_q  <= regs[RS1];
            b_q  <= regs[RS2];
            op_q <= Op;
            rd_q <= RD;
            cnt  <= {1'b0, ShiftCount};
`ifdef REG_ALU_MULT_EN
            p_hi <= '0;
            if (Op == OP_MUL) cnt <= CNT_MUL;
`endif
          end
        end
        S_SHIFT: begin
          a_q <= shift_nx;
          cnt <= cnt - CNT_ONE;
        end
`ifdef REG_ALU_MULT_EN
        // b_q doubles as the low product half as multiplier bits retire
        S_MUL: begin
          {p_hi, b_q} <= {mul_sum, b_q[MSB:1]};
          cnt         <= cnt - CNT_ONE;
        end
`endif
        default: ;
      endcase
      if (wb_en) regs[rd_q] <= wb_val;
      else if (ExtWE && !Busy && !Start) regs[ExtWR] <= ExtWD;
    end
  end

endmodule

// File: tb/tb_reg_alu_core.sv
// tb_reg_alu_core: directed and random ops against a behavioural model.
`timescale 1ns/1ps
module tb_reg_alu_core;

  logic        Clk, Rst_n, Start, ExtWE;
  logic [3:0]  Op;
  logic [4:0]  RS1, RS2, RD, ShiftCount, ExtWR, DbgAddr;
  logic [31:0] ExtWD, DbgData, Result;
  logic        Busy, Done, Zero, Overflow;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] mdl [32];

  localparam longint MAXI = 64'sh7FFFFFFF;
  localparam longint MINI = -MAXI - 1;

  reg_alu_core #(.WIDTH(32), .DEPTH(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op),
    .RS1(RS1), .RS2(RS2), .RD(RD), .ShiftCount(ShiftCount),
    .ExtWE(ExtWE), .ExtWR(ExtWR), .ExtWD(ExtWD),
    .DbgAddr(DbgAddr), .DbgData(DbgData),
    .Busy(Busy), .Done(Done), .Zero(Zero),
    .Overflow(Overflow), .Result(Result)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sc,
                                output logic [31:0] r, output logic ov,
                                output int lat);
    longint sa, sb, s;
    longint unsigned p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = '0;
    ov  = 1'b0;
    lat = 1;
    p   = '0;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: begin
        s  = sa + sb;
        r  = s[31:0];
        ov = (s > MAXI) || (s < MINI);
      end
      4'h6: begin
        s  = sa - sb;
        r  = s[31:0];
        ov = (s > MAXI) || (s < MINI);
      end
      4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
      4'h8: r = (sa > sb) ? 32'd1 : 32'd0;
      4'hC: r = ~(a | b);
      4'hD: r = a >> sc;
      4'hE: r = a << sc;
      4'hF: r = 32'($signed(a) >>> sc);
`ifdef REG_ALU_MULT_EN
      4'h3: begin
        p   = 64'(a) * 64'(b);
        r   = p[31:0];
        ov  = (p >> 32) != 0;
        lat = 33;
      end
`endif
      default: r = '0;
    endcase
    if ((op == 4'hD || op == 4'hE || op == 4'hF) && sc != 0)
      lat = int'(sc) + 1;
  endfunction

  task automatic ext_write(input logic [4:0] a, input logic [31:0] d);
    Start = 1'b0;
    ExtWE = 1'b1;
    ExtWR = a;
    ExtWD = d;
    @(negedge Clk);
    ExtWE = 1'b0;
    mdl[a] = d;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] d,
                        input logic [4:0] sc);
    logic [31:0] er;
    logic        eo;
    int          el, k;
    model(op, mdl[s1], mdl[s2], sc, er, eo, el);
    Start = 1'b1; ExtWE = 1'b0;
    Op = op; RS1 = s1; RS2 = s2; RD = d; ShiftCount = sc;
    k = 0;
    do begin
      @(negedge Clk);
      k++;
      if (k == 1) begin
        chk("busy", 64'(Busy), 64'(1));
        chk("done_pulse", 64'(Done), 64'(0));
      end
      if (!Done) begin
        Start = 1'($urandom); ExtWE = 1'($urandom);
        ExtWR = 5'($urandom); ExtWD = $urandom;
        Op = 4'($urandom); RS1 = 5'($urandom); RS2 = 5'($urandom);
        RD = 5'($urandom); ShiftCount = 5'($urandom);
      end
    end while (!Done && k < 100);
    Start = 1'b0;
    ExtWE = 1'b0;
    mdl[d] = er;
    chk("latency", 64'(k - 1), 64'(el));
    chk("result", 64'(Result), 64'(er));
    chk("zero", 64'(Zero), 64'(er == 0));
    chk("overflow", 64'(Overflow), 64'(eo));
    chk("busy_end", 64'(Busy), 64'(0));
    DbgAddr = d;
    #1;
    chk("writeback", 64'(DbgData), 64'(er));
  endtask

  task automatic chk_regs();
    for (int i = 0; i < 32; i++) begin
      DbgAddr = 5'(i);
      #1;
      chk("regfile", 64'(DbgData), 64'(mdl[i]));
    end
    @(negedge Clk);
  endtask

  logic [31:0] vals [6];
  int          seen;

  initial begin
    Rst_n = 1'b0; Start = 1'b0; ExtWE = 1'b0; Op = '0;
    RS1 = '0; RS2 = '0; RD = '0; ShiftCount = '0;
    ExtWR = '0; ExtWD = '0; DbgAddr = 5'd7;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    vals[0] = 32'h0; vals[1] = 32'hFFFF_FFFF; vals[2] = 32'h7FFF_FFFF;
    vals[3] = 32'h8000_0000; vals[4] = 32'h1; vals[5] = 32'h0001_0000;
    #13;
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    chk("rst_result", 64'(Result), 64'(0));
    chk("rst_zero", 64'(Zero), 64'(0));
    chk("rst_ovf", 64'(Overflow), 64'(0));
    chk("rst_reg", 64'(DbgData), 64'(0));
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    ext_write(5'd0, 32'hFFFF_FFFE);
    ext_write(5'd1, 32'd1200);
    run_op(4'h2, 5'd0, 5'd1, 5'd2, 5'd0);
    ext_write(5'd3, 32'h7FFF_FFFF);
    ext_write(5'd4, 32'd1);
    run_op(4'h2, 5'd3, 5'd4, 5'd5, 5'd0);
    run_op(4'h6, 5'd0, 5'd0, 5'd6, 5'd0);
    run_op(4'hF, 5'd0, 5'd1, 5'd7, 5'd2);
    run_op(4'hD, 5'd0, 5'd1, 5'd8, 5'd2);
    run_op(4'hE, 5'd0, 5'd1, 5'd9, 5'd0);
    run_op(4'h8, 5'd0, 5'd1, 5'd10, 5'd0);
    run_op(4'h7, 5'd0, 5'd1, 5'd11, 5'd0);
    chk_regs();
    ext_write(5'd13, 32'd1300);
    run_op(4'h3, 5'd1, 5'd13, 5'd14, 5'd0);
    ext_write(5'd15, 32'h0001_0000);
    run_op(4'h3, 5'd15, 5'd15, 5'd16, 5'd0);
    run_op(4'h2, 5'd2, 5'd2, 5'd2, 5'd0);
    run_op(4'h2, 5'd2, 5'd1, 5'd17, 5'd0);
    run_op(4'h6, 5'd3, 5'd6, 5'd18, 5'd31);
    run_op(4'hE, 5'd4, 5'd4, 5'd19, 5'd31);

    for (int t = 0; t < 120; t++) begin
      if ($urandom_range(0, 9) < 3) begin
        if ($urandom_range(0, 1) == 1)
          ext_write(5'($urandom), vals[$urandom_range(0, 5)]);
        else
          ext_write(5'($urandom), $urandom);
      end
      run_op(4'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 5'($urandom));
    end
    chk_regs();

    Start = 1'b1; Op = 4'hF; RS1 = 5'd0; RS2 = 5'd0;
    RD = 5'd20; ShiftCount = 5'd20;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(Busy), 64'(0));
    chk("abort_done", 64'(Done), 64'(0));
    chk("abort_result", 64'(Result), 64'(0));
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int i = 0; i < 32; i++) begin
      DbgAddr = 5'(i);
      #1;
      chk("abort_reg", 64'(DbgData), 64'(0));
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge Clk);
      if (Done) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'(0));
    ext_write(5'd1, 32'd5);
    run_op(4'h2, 5'd1, 5'd1, 5'd2, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
